// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the FE/DE/EXE/MEM/WB core. Generates every stall,
//   bubble and flush strobe around decode:
//     - load-use hazards that decode forwarding cannot cover (one bubble),
//     - holding fetch while a control transfer in EXE is unresolved,
//     - freezing the pipe while memory is not ready,
//     - flushing on a WB trap and draining before fetch resumes at DE_MTVEC.
//
// Parameters
//   TRAP_DRAIN  cycles fetch stays held after a trap flush (1..7)
//   BR_TIMEOUT  BR_WAIT cycles without resolution before BR_ERR (1..255)
//
// Ports
//   CLK, RESET_N        clock (rising edge), asynchronous active-low reset
//   DE_V, DE_IR         decode latch valid / instruction
//   EXE_V, EXE_IR       execute latch valid / instruction
//   V_MEM_STALL         memory stage not ready
//   BR_RESOLVE          pulse: control transfer in EXE resolved
//   WB_CS               pulse: trap taken in WB
//   STALL_FE            hold PC and FE->DE latch
//   STALL_DE            hold DE->EXE latch
//   BUBBLE_EXE          load EXE_V=0 this cycle
//   FLUSH_ALL           clear DE/EXE/MEM valid bits
//   PC_SEL_TRAP         next PC = DE_MTVEC
//   BR_ERR              sticky: branch never resolved
//   STATE               current FSM state (debug)
//
// Optional feature
//   HAZARD_PERF_EN      when defined, adds PERF_LU / PERF_BR / PERF_MEM cycle
//                       counters (cycles in LU, in BR_WAIT, with V_MEM_STALL).
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int TRAP_DRAIN = 3,
  parameter int BR_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DE_V,
  input  logic [31:0] DE_IR,
  input  logic        EXE_V,
  input  logic [31:0] EXE_IR,
  input  logic        V_MEM_STALL,
  input  logic        BR_RESOLVE,
  input  logic        WB_CS,
  output logic        STALL_FE,
  output logic        STALL_DE,
  output logic        BUBBLE_EXE,
  output logic        FLUSH_ALL,
  output logic        PC_SEL_TRAP,
  output logic        BR_ERR,
  output logic [2:0]  STATE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] PERF_LU,
  output logic [31:0] PERF_BR,
  output logic [31:0] PERF_MEM
`endif
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LU      = 3'd1,
    ST_BR_WAIT = 3'd2,
    ST_TRAP    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_reg, state_next;
  logic [2:0]  drain_reg, drain_next;
  logic [7:0]  to_reg, to_next;
  logic        err_reg, err_next;

  logic        stall_fe, stall_de, bubble_exe, flush_all, pc_sel_trap;
  logic [7:0]  to_inc;

  // ------------------------------------------------------------------
  // Hazard decode
  // ------------------------------------------------------------------
  logic [6:0] de_op;
  logic [4:0] de_rs1, de_rs2, exe_rd;
  logic       de_uses_rs2, load_use, ctrl_xfer;

  assign de_op  = DE_IR[6:0];
  assign de_rs1 = DE_IR[19:15];
  assign de_rs2 = DE_IR[24:20];
  assign exe_rd = EXE_IR[11:7];

  // Only these formats actually read rs2; elsewhere bits [24:20] are immediate.
  assign de_uses_rs2 = (de_op == OP_OP) || (de_op == OP_OP32) ||
                       (de_op == OP_STORE) || (de_op == OP_BRANCH);

  // x0 as destination never creates a dependency.
  assign load_use = DE_V && EXE_V && (EXE_IR[6:0] == OP_LOAD) && (exe_rd != 5'd0) &&
                    ((exe_rd == de_rs1) || (de_uses_rs2 && (exe_rd == de_rs2)));

  assign ctrl_xfer = DE_V && ((de_op == OP_BRANCH) || (de_op == OP_JAL) || (de_op == OP_JALR));

  // Instruction bits not involved in hazard detection.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{DE_IR[31:25], DE_IR[14:7], EXE_IR[31:12]};

  // Saturating timeout increment.
  assign to_inc = (to_reg == 8'hFF) ? to_reg : to_reg + 8'd1;

  // ------------------------------------------------------------------
  // Next state and strobes
  // ------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    drain_next  = drain_reg;
    to_next     = to_reg;
    err_next    = err_reg;
    stall_fe    = 1'b0;
    stall_de    = 1'b0;
    bubble_exe  = 1'b0;
    flush_all   = 1'b0;
    pc_sel_trap = 1'b0;

    if (WB_CS) begin
      // Trap overrides everything, including a same-cycle BR_RESOLVE.
      flush_all   = 1'b1;
      pc_sel_trap = 1'b1;
      to_next     = 8'd0;
      state_next  = ST_TRAP;
    end else if (V_MEM_STALL) begin
      // Whole pipe frozen: state, drain and timeout counters all hold.
      stall_fe = 1'b1;
      stall_de = 1'b1;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (load_use) begin
            stall_fe   = 1'b1;
            stall_de   = 1'b1;
            bubble_exe = 1'b1;
            state_next = ST_LU;
          end else if (ctrl_xfer) begin
            // Transfer moves on to EXE this cycle; fetch is held from next cycle.
            to_next    = 8'd0;
            state_next = ST_BR_WAIT;
          end
        end
        ST_LU: begin
          state_next = ST_RUN;
        end
        ST_BR_WAIT: begin
          stall_fe = 1'b1;
          if (BR_RESOLVE) begin
            to_next    = 8'd0;
            state_next = ST_RUN;
          end else begin
            to_next = to_inc;
            if (to_inc >= 8'(BR_TIMEOUT)) begin
              err_next = 1'b1;
            end
          end
        end
        ST_TRAP: begin
          stall_fe   = 1'b1;
          bubble_exe = 1'b1;
          drain_next = 3'(TRAP_DRAIN - 1);
          state_next = (TRAP_DRAIN == 1) ? ST_RUN : ST_DRAIN;
        end
        ST_DRAIN: begin
          stall_fe   = 1'b1;
          bubble_exe = 1'b1;
          // Leave when this decrement reaches zero so the total hold is TRAP_DRAIN cycles.
          if (drain_reg <= 3'd1) begin
            drain_next = 3'd0;
            state_next = ST_RUN;
          end else begin
            drain_next = drain_reg - 3'd1;
          end
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_RUN;
      drain_reg <= 3'd0;
      to_reg    <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
      to_reg    <= to_next;
      err_reg   <= err_next;
    end
  end

  // Strobes are forced low while reset is asserted, whatever the inputs do.
  assign STALL_FE    = RESET_N & stall_fe;
  assign STALL_DE    = RESET_N & stall_de;
  assign BUBBLE_EXE  = RESET_N & bubble_exe;
  assign FLUSH_ALL   = RESET_N & flush_all;
  assign PC_SEL_TRAP = RESET_N & pc_sel_trap;
  assign BR_ERR      = err_reg;
  assign STATE       = state_reg;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_reg, perf_br_reg, perf_mem_reg;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      perf_lu_reg  <= 32'd0;
      perf_br_reg  <= 32'd0;
      perf_mem_reg <= 32'd0;
    end else begin
      if (state_reg == ST_LU)      perf_lu_reg  <= perf_lu_reg + 32'd1;
      if (state_reg == ST_BR_WAIT) perf_br_reg  <= perf_br_reg + 32'd1;
      if (V_MEM_STALL)             perf_mem_reg <= perf_mem_reg + 32'd1;
    end
  end

  assign PERF_LU  = perf_lu_reg;
  assign PERF_BR  = perf_br_reg;
  assign PERF_MEM = perf_mem_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl (TRAP_DRAIN=3, BR_TIMEOUT=15).
//   Each scenario is a table of per-cycle inputs with the strobes/state
//   expected in that cycle; expectations go into a scoreboard queue when the
//   inputs are driven and are popped and compared at the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        CLK;
  logic        RESET_N;
  logic        DE_V;
  logic [31:0] DE_IR;
  logic        EXE_V;
  logic [31:0] EXE_IR;
  logic        V_MEM_STALL;
  logic        BR_RESOLVE;
  logic        WB_CS;
  logic        STALL_FE, STALL_DE, BUBBLE_EXE, FLUSH_ALL, PC_SEL_TRAP, BR_ERR;
  logic [2:0]  STATE;
`ifdef HAZARD_PERF_EN
  logic [31:0] PERF_LU, PERF_BR, PERF_MEM;
`endif

  hazard_ctrl #(.TRAP_DRAIN(3), .BR_TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .DE_V(DE_V), .DE_IR(DE_IR), .EXE_V(EXE_V), .EXE_IR(EXE_IR),
    .V_MEM_STALL(V_MEM_STALL), .BR_RESOLVE(BR_RESOLVE), .WB_CS(WB_CS),
    .STALL_FE(STALL_FE), .STALL_DE(STALL_DE), .BUBBLE_EXE(BUBBLE_EXE),
    .FLUSH_ALL(FLUSH_ALL), .PC_SEL_TRAP(PC_SEL_TRAP), .BR_ERR(BR_ERR),
    .STATE(STATE)
`ifdef HAZARD_PERF_EN
    , .PERF_LU(PERF_LU), .PERF_BR(PERF_BR), .PERF_MEM(PERF_MEM)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          rst_n;
    bit          de_v;
    logic [31:0] de_ir;
    bit          exe_v;
    logic [31:0] exe_ir;
    bit          mem;
    bit          res;
    bit          wb;
    logic [8:0]  exp;
  } stim_t;

  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Instruction encoders
  function automatic logic [31:0] i_ld(int rd, int rs1);
    return {12'd0, 5'(rs1), 3'b011, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] i_add(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_sw(int rs2, int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] i_addi(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] i_beq(int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] i_jal(int rd);
    return {20'd0, 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] i_jalr(int rd, int rs1);
    return {12'd0, 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
  endfunction

  // Expected vector: {STATE, BR_ERR, PC_SEL_TRAP, FLUSH_ALL, BUBBLE_EXE, STALL_DE, STALL_FE}
  function automatic logic [8:0] ev(int st, bit fe, bit de, bit bub, bit fl, bit pc, bit err);
    return {3'(st), err, pc, fl, bub, de, fe};
  endfunction

  function automatic logic [8:0] obs();
    return {STATE, BR_ERR, PC_SEL_TRAP, FLUSH_ALL, BUBBLE_EXE, STALL_DE, STALL_FE};
  endfunction

  function automatic stim_t mk(bit rst_n, bit de_v, logic [31:0] de_ir, bit exe_v,
                               logic [31:0] exe_ir, bit mem, bit res, bit wb, logic [8:0] exp);
    stim_t s;
    s.rst_n = rst_n; s.de_v = de_v; s.de_ir = de_ir; s.exe_v = exe_v; s.exe_ir = exe_ir;
    s.mem = mem; s.res = res; s.wb = wb; s.exp = exp;
    return s;
  endfunction

  function automatic stim_t idle(logic [8:0] exp);
    return mk(1, 0, NOP, 0, NOP, 0, 0, 0, exp);
  endfunction

  // Drive one cycle of inputs and record what the DUT owes for it.
  task automatic apply(input stim_t s);
    RESET_N     = s.rst_n;
    DE_V        = s.de_v;
    DE_IR       = s.de_ir;
    EXE_V       = s.exe_v;
    EXE_IR      = s.exe_ir;
    V_MEM_STALL = s.mem;
    BR_RESOLVE  = s.res;
    WB_CS       = s.wb;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    stim_t t[$];
    logic [8:0] e, o;
    t.push_back(mk(0, 1, i_add(6, 5, 1), 1, i_ld(5, 2), 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(mk(0, 1, i_beq(1, 2), 0, NOP, 1, 1, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      @(posedge CLK); #1;
      apply(t[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      o = obs();
      n_cmp++;
      $display("[reset] cyc %0d obs=%b exp=%b", i, o, e);
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %b required %b", i, o, e);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    logic [8:0] e, o;
    // rs1 dependency: one bubble, STATE 0 -> 1 -> 0
    t.push_back(mk(1, 1, i_add(6, 5, 1), 1, i_ld(5, 2), 0, 0, 0, ev(0, 1, 1, 1, 0, 0, 0)));
    t.push_back(mk(1, 1, i_add(6, 5, 1), 0, NOP, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    // x0 destination never stalls
    t.push_back(mk(1, 1, i_add(6, 0, 1), 1, i_ld(0, 2), 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    // store data register (rs2 path)
    t.push_back(mk(1, 1, i_sw(5, 2), 1, i_ld(5, 3), 0, 0, 0, ev(0, 1, 1, 1, 0, 0, 0)));
    t.push_back(mk(1, 1, i_sw(5, 2), 0, NOP, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0)));
    // addi immediate whose rs2 field aliases rd: not a real read
    t.push_back(mk(1, 1, i_addi(6, 1, 5), 1, i_ld(5, 3), 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    // DE invalid: no detection
    t.push_back(mk(1, 0, i_add(6, 5, 1), 1, i_ld(5, 2), 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    // branch reading the load result: load-use wins over the transfer
    t.push_back(mk(1, 1, i_beq(1, 5), 1, i_ld(5, 2), 0, 0, 0, ev(0, 1, 1, 1, 0, 0, 0)));
    t.push_back(mk(1, 0, NOP, 0, NOP, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      @(posedge CLK); #1;
      apply(t[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      o = obs();
      n_cmp++;
      $display("[load_use] cyc %0d obs=%b exp=%b", i, o, e);
      if (o !== e) begin
        n_bad++;
        $display("FAIL load_use cyc %0d: got %b required %b", i, o, e);
      end
    end
  endtask

  task automatic test_branch();
    stim_t t[$];
    logic [8:0] e, o;
    // beq, resolve four cycles later: STALL_FE for exactly four cycles
    t.push_back(mk(1, 1, i_beq(1, 2), 0, NOP, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(2, 1, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(2, 1, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(2, 1, 0, 0, 0, 0, 0)));
    t.push_back(mk(1, 0, NOP, 0, NOP, 0, 1, 0, ev(2, 1, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    // jal, resolved immediately
    t.push_back(mk(1, 1, i_jal(1), 0, NOP, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(mk(1, 0, NOP, 0, NOP, 0, 1, 0, ev(2, 1, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    // jalr
    t.push_back(mk(1, 1, i_jalr(1, 7), 0, NOP, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(mk(1, 0, NOP, 0, NOP, 0, 1, 0, ev(2, 1, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      @(posedge CLK); #1;
      apply(t[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      o = obs();
      n_cmp++;
      $display("[branch] cyc %0d obs=%b exp=%b", i, o, e);
      if (o !== e) begin
        n_bad++;
        $display("FAIL branch cyc %0d: got %b required %b", i, o, e);
      end
    end
  endtask

  task automatic test_trap();
    stim_t t[$];
    logic [8:0] e, o;
    // trap during BR_WAIT: flush 1 cycle, then STATE 3,4,4,0
    t.push_back(mk(1, 1, i_beq(3, 4), 0, NOP, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(2, 1, 0, 0, 0, 0, 0)));
    t.push_back(mk(1, 0, NOP, 0, NOP, 0, 0, 1, ev(2, 0, 0, 0, 1, 1, 0)));
    t.push_back(idle(ev(3, 1, 0, 1, 0, 0, 0)));
    t.push_back(idle(ev(4, 1, 0, 1, 0, 0, 0)));
    t.push_back(idle(ev(4, 1, 0, 1, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    // WB_CS and BR_RESOLVE together: the trap wins
    t.push_back(mk(1, 1, i_beq(3, 4), 0, NOP, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(mk(1, 0, NOP, 0, NOP, 0, 1, 1, ev(2, 0, 0, 0, 1, 1, 0)));
    t.push_back(idle(ev(3, 1, 0, 1, 0, 0, 0)));
    t.push_back(idle(ev(4, 1, 0, 1, 0, 0, 0)));
    t.push_back(idle(ev(4, 1, 0, 1, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      @(posedge CLK); #1;
      apply(t[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      o = obs();
      n_cmp++;
      $display("[trap] cyc %0d obs=%b exp=%b", i, o, e);
      if (o !== e) begin
        n_bad++;
        $display("FAIL trap cyc %0d: got %b required %b", i, o, e);
      end
    end
  endtask

  task automatic test_mem_stall();
    stim_t t[$];
    logic [8:0] e, o;
    // trap from RUN, then memory stall for 5 cycles inside DRAIN
    t.push_back(mk(1, 0, NOP, 0, NOP, 0, 0, 1, ev(0, 0, 0, 0, 1, 1, 0)));
    t.push_back(idle(ev(3, 1, 0, 1, 0, 0, 0)));
    for (int k = 0; k < 5; k++)
      t.push_back(mk(1, 0, NOP, 0, NOP, 1, 0, 0, ev(4, 1, 1, 0, 0, 0, 0)));
    t.push_back(idle(ev(4, 1, 0, 1, 0, 0, 0)));
    t.push_back(idle(ev(4, 1, 0, 1, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    // memory stall outranks a load-use hazard; no LU afterwards
    t.push_back(mk(1, 1, i_add(6, 5, 1), 1, i_ld(5, 2), 1, 0, 0, ev(0, 1, 1, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    // memory stall during BR_WAIT holds the state
    t.push_back(mk(1, 1, i_beq(1, 2), 0, NOP, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(mk(1, 0, NOP, 0, NOP, 1, 0, 0, ev(2, 1, 1, 0, 0, 0, 0)));
    t.push_back(mk(1, 0, NOP, 0, NOP, 0, 1, 0, ev(2, 1, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      @(posedge CLK); #1;
      apply(t[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      o = obs();
      n_cmp++;
      $display("[mem_stall] cyc %0d obs=%b exp=%b", i, o, e);
      if (o !== e) begin
        n_bad++;
        $display("FAIL mem_stall cyc %0d: got %b required %b", i, o, e);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t t[$];
    logic [8:0] e, o;
    t.push_back(mk(1, 1, i_beq(1, 2), 0, NOP, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
    // BR_ERR appears once 15 BR_WAIT cycles have gone by unresolved
    for (int j = 1; j <= 17; j++)
      t.push_back(idle(ev(2, 1, 0, 0, 0, 0, (j >= 16))));
    // reset mid-wait clears state and BR_ERR immediately
    t.push_back(mk(0, 1, i_beq(1, 2), 0, NOP, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(idle(ev(0, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      @(posedge CLK); #1;
      apply(t[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      o = obs();
      n_cmp++;
      $display("[timeout] cyc %0d obs=%b exp=%b", i, o, e);
      if (o !== e) begin
        n_bad++;
        $display("FAIL timeout cyc %0d: got %b required %b", i, o, e);
      end
    end
  endtask

  initial begin
    RESET_N     = 1'b0;
    DE_V        = 1'b0;
    DE_IR       = NOP;
    EXE_V       = 1'b0;
    EXE_IR      = NOP;
    V_MEM_STALL = 1'b0;
    BR_RESOLVE  = 1'b0;
    WB_CS       = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_trap();
    test_mem_stall();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
